// File: rtl/mux_memoria_param.sv
// N-channel registered multiplexer with valid qualification, round-robin mode and rising-bit counter.
// Optional build macro MUX_SEL_ERR_EN adds a sticky out-of-range selector flag (sel_err).
module mux_memoria_param #(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 4,
    localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          selector,
    input  logic [CHANNELS-1:0]       valid_in,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]          data_out,
    output logic                      valid_out,
    output logic [SEL_W-1:0]          chan_out,
`ifdef MUX_SEL_ERR_EN
    output logic                      sel_err,
`endif
    output logic [CNT_W-1:0]          rise_count
);

    logic [SEL_W-1:0] rr_ptr;
    logic             grant;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] next_data;
    logic [CNT_W-1:0] next_count;
    logic [SEL_W-1:0] next_ptr;
    int unsigned      idx;
    int unsigned      rises;
    int unsigned      sum;

    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (!mode) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (selector == SEL_W'(i) && valid_in[i]) begin
                    grant     = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            // first valid channel at or after rr_ptr, wrapping past CHANNELS-1
            for (int unsigned off = 0; off < CHANNELS; off++) begin
                idx = 32'(rr_ptr) + off;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                if (!grant && valid_in[idx]) begin
                    grant     = 1'b1;
                    grant_idx = SEL_W'(idx);
                end
            end
        end
    end

    always_comb begin
        next_data = data_out;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant_idx == SEL_W'(i)) next_data = data_in[i*WIDTH +: WIDTH];
        end
        rises = 0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            if (!data_out[b] && next_data[b]) rises = rises + 1;
        end
        sum = 32'(rise_count) + rises;
        next_count = (sum > (32'd1 << CNT_W) - 1) ? '1 : CNT_W'(sum);
        next_ptr   = (32'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out   <= '0;
            valid_out  <= 1'b0;
            chan_out   <= '0;
            rise_count <= '0;
            rr_ptr     <= '0;
        end else begin
            valid_out <= grant;
            if (grant) begin
                data_out   <= next_data;
                chan_out   <= grant_idx;
                rise_count <= next_count;
                if (mode) rr_ptr <= next_ptr;
            end
        end
    end

`ifdef MUX_SEL_ERR_EN
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sel_err <= 1'b0;
        end else if (!mode && 32'(selector) >= CHANNELS) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/mux_memoria_param.md
Name: mux_memoria_param

Overview:
Parametrised N-channel multiplexer with output memory, succeeding the fixed 2-channel, 2-bit mux with memory. It registers the selected channel onto data_out and holds the last value when nothing valid is selected. It adds per-channel valid qualification, a round-robin selection mode and an on-chip rising-bit counter. This counter takes over the transition count the probador currently computes in the testbench.

Parameters:
WIDTH, 2, data width of every channel and of data_out
CHANNELS, 4, number of input channels (legal range 2..8)
CNT_W, 4, width of the rising-bit counter
SEL_W (localparam), max(1, clog2(CHANNELS)), width of selector and chan_out

Ports:
clk  input  1  single clock; all state updates on posedge
reset_L  input  1  asynchronous, active-low reset
mode  input  1  selection mode: 0 = external selector, 1 = round-robin
selector  input  SEL_W  channel index, used only when mode=0
valid_in  input  CHANNELS  per-channel valid; bit i qualifies channel i
data_in  input  CHANNELS*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH]
data_out  output  WIDTH  registered selected data; holds its value when no grant occurs
valid_out  output  1  1 for one cycle after each grant
chan_out  output  SEL_W  index of the last granted channel
rise_count  output  CNT_W  saturating count of data_out bits that went from 0 to 1

Behaviour:
- Reset:
  - Reset is asynchronous: reset_L=0 immediately clears data_out, valid_out, chan_out, rise_count and the internal round-robin pointer rr_ptr.
  - Reset release is sampled on the first posedge with reset_L=1.
- Latency: 1 clock. Inputs sampled at edge N appear on the outputs after edge N.
- Mode 0 (external selector):
  - Grant condition: selector < CHANNELS and valid_in[selector]=1.
  - On grant: data_out <= channel[selector], valid_out <= 1, chan_out <= selector.
  - Otherwise: data_out and chan_out hold, valid_out <= 0.
  - selector >= CHANNELS (possible when CHANNELS is not a power of two) is treated as no grant.
- Mode 1 (round-robin):
  - Search channels starting at rr_ptr, ascending with wrap-around, for the first set valid_in bit.
  - On grant of channel g: data_out <= channel[g], valid_out <= 1, chan_out <= g, rr_ptr <= (g+1) mod CHANNELS.
  - If valid_in is all zeros: hold data_out and chan_out, valid_out <= 0, rr_ptr unchanged.
- Mode switching:
  - A change of mode takes effect at the next edge; no flush occurs.
  - rr_ptr keeps its value while mode=0 and is not updated by mode-0 grants.
- rise_count:
  - On every edge with a grant: rise_count <= rise_count + popcount(~data_out_q & next_data).
  - The sum saturates at 2^CNT_W - 1.
  - Unchanged when there is no grant.
  - Only reset clears it.
- Regranting the same data: valid_out still pulses and rise_count adds 0.
- Any X on selector or valid_in is a bench error; no recovery is defined.

Optional Feature:
MUX_SEL_ERR_EN
- Defined:
  - Adds output sel_err (1 bit) and a sticky register behind it.
  - sel_err is set on any edge where mode=0 and selector >= CHANNELS.
  - sel_err is cleared only by reset_L=0 and is 0 out of reset.
- Not defined:
  - The port and register are absent.
  - The out-of-range selector is still silently treated as no grant.
- Data path behaviour is identical in both builds.

Test Plan:
1. CHANNELS=4, WIDTH=2, mid-run with data_out=11 and rise_count=5, drive reset_L=0 between clock edges -> all outputs 0 before the next posedge. After release, the first grant from rr_ptr=0 selects channel 0.
2. mode=0, selector=2, valid_in=4'b0100, ch2=2'b11 -> after one edge: data_out=11, valid_out=1, chan_out=2, rise_count=2.
3. Continue with mode=0, selector=1, valid_in=4'b0100 -> data_out stays 11, chan_out stays 2, valid_out=0, rise_count stays 2.
4. After reset, mode=1, valid_in=4'b1111 held for 5 edges -> chan_out sequence 0,1,2,3,0 with valid_out=1 every cycle. Then valid_in=4'b1010 -> grants 1,3,1,3.
5. CNT_W=2, mode=0, selector=0, valid_in=1, ch0 driven 11,00,11 on consecutive edges -> rise_count 2,2,3 (saturated).
6. MUX_SEL_ERR_EN defined, CHANNELS=3, mode=0, selector=3, valid_in=3'b111 -> no grant, valid_out=0, data_out held, sel_err=1. sel_err stays 1 after selector=0 and returns to 0 only after reset_L=0.
